// File: rtl/featuremap_stream_source_pkg.sv
// ---------------------------------------------------------------------------
// featuremap_stream_pkg
// Shared definitions for the feature-map raster streamer:
//   - default channel width / channel count
//   - FSM state encoding (IDLE / RUN / DRAIN)
//   - packed pixel word type for the default geometry
//   - counter width helper
// ---------------------------------------------------------------------------
package featuremap_stream_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32'd32;
  localparam int unsigned DEF_NUM_CH     = 32'd32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } fsm_state_e;

  typedef logic [DEF_NUM_CH*DEF_DATA_WIDTH-1:0] pixel_t;

  // Bits needed to hold the values 0..n-1 (never less than one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 32'd2) ? 32'd1 : $clog2(n);
  endfunction

endpackage

// File: rtl/featuremap_stream_source_if.sv
// ---------------------------------------------------------------------------
// featuremap_stream_source_if
// Valid/ready pixel stream between the streamer and a featuremap sink.
//   data_out  : packed pixel (PIX_W bits)
//   valid_out : data_out holds a beat
//   ready_in  : sink accepts the beat when valid_out & ready_in
// Modports: master = streamer side, slave = sink side.
// ---------------------------------------------------------------------------
interface featuremap_stream_source_if #(
  parameter int unsigned PIX_W = 32'd1024
) ();
  logic [PIX_W-1:0] data_out;
  logic             valid_out;
  logic             ready_in;

  modport master (output data_out, output valid_out, input ready_in);
  modport slave  (input data_out, input valid_out, output ready_in);
endinterface

// File: rtl/featuremap_stream_source_skid_fifo.sv
// ---------------------------------------------------------------------------
// stream_skid_fifo
// Two-entry registered FIFO whose head register drives the stream directly,
// so data_out/valid_out come straight from flops.
//   clk, rst_n     : clock, async active-low reset
//   push/push_data : write one word (caller guarantees not full)
//   pop            : head consumed this cycle (only while valid_out)
//   count          : current occupancy 0..2
//   data_out       : head entry
//   valid_out      : FIFO not empty
// ---------------------------------------------------------------------------
module stream_skid_fifo #(
  parameter int unsigned W = 32'd32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [1:0]   count,
  output logic [W-1:0] data_out,
  output logic         valid_out
);

  logic [W-1:0] head_d, head_q;
  logic [W-1:0] tail_d, tail_q;
  logic [1:0]   count_d, count_q;
  logic         valid_d, valid_q;

  // Next FIFO contents; the head only moves on a pop or a push into empty.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) begin
          head_d = push_data;
        end else begin
          tail_d = push_data;
        end
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          head_d = push_data;
        end else begin
          head_d = tail_q;
          tail_d = push_data;
        end
        count_d = count_q;
      end
      default: begin
        count_d = count_q;
      end
    endcase
    valid_d = (count_d != 2'd0);
  end

  // FIFO storage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= {W{1'b0}};
      tail_q  <= {W{1'b0}};
      count_q <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  assign count     = count_q;
  assign data_out  = head_q;
  assign valid_out = valid_q;

endmodule

// File: rtl/featuremap_stream_source.sv
// ---------------------------------------------------------------------------
// featuremap_stream_source
// Streams one IMG_SIZE x IMG_SIZE feature-map frame in raster order from a
// buffer with 1-cycle read latency onto a valid/ready pixel stream.
//   clk, rst_n   : clock, async active-low reset
//   start        : frame request, sampled only while idle
//   busy         : frame in progress
//   done         : one-cycle pulse after the final beat
//   mem_rd_en    : buffer read strobe
//   mem_addr     : buffer read address
//   mem_rd_data  : read data, valid the cycle after mem_rd_en
//   strm         : pixel stream (master modport)
// Optional build macro FEATUREMAP_STREAM_SRC_ZERO_PAD_EN adds a one-pixel
// zero border, giving (IMG_SIZE+2)^2 beats; border beats issue no read.
// ---------------------------------------------------------------------------
module featuremap_stream_source
  import featuremap_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned NUM_CH     = DEF_NUM_CH,
  parameter int unsigned IMG_SIZE   = 32'd104,
  parameter int unsigned ADDR_WIDTH = 32'd14
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic                         mem_rd_en,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  input  logic [NUM_CH*DATA_WIDTH-1:0] mem_rd_data,
  featuremap_stream_source_if.master   strm
);

  localparam int unsigned PIX_W = NUM_CH * DATA_WIDTH;
`ifdef FEATUREMAP_STREAM_SRC_ZERO_PAD_EN
  localparam int unsigned SIDE  = IMG_SIZE + 32'd2;
`else
  localparam int unsigned SIDE  = IMG_SIZE;
`endif
  localparam int unsigned RC_W  = cnt_width(SIDE);
  localparam logic [RC_W-1:0]       RC_LAST   = RC_W'(SIDE - 32'd1);
  localparam logic [RC_W-1:0]       RC_ONE    = RC_W'(32'd1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(IMG_SIZE * IMG_SIZE - 32'd1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(32'd1);

  fsm_state_e            state_d, state_q;
  logic [RC_W-1:0]       row_d, row_q;
  logic [RC_W-1:0]       col_d, col_q;
  logic [ADDR_WIDTH-1:0] addr_d, addr_q;
  logic                  inflight_d, inflight_q;
  logic                  done_d, done_q;

  logic [1:0]            fifo_count_s;
  logic [PIX_W-1:0]      push_data_s;
  logic                  pop_s;
  logic [2:0]            occ_s;
  logic                  issue_s;
  logic                  rd_issue_s;
  logic                  last_pos_s;
  logic                  final_pop_s;
`ifdef FEATUREMAP_STREAM_SRC_ZERO_PAD_EN
  logic                  pad_pos_s;
  logic                  inflight_pad_d, inflight_pad_q;
`endif

  // Issue decision: buffered beats plus the outstanding read, after this
  // cycle's pop, must stay below two so the skid buffer can never overflow.
  always_comb begin
    pop_s       = strm.valid_out & strm.ready_in;
    occ_s       = {1'b0, fifo_count_s} + {2'b00, inflight_q} - {2'b00, pop_s};
    issue_s     = (state_q == ST_RUN) && (occ_s < 3'd2);
    last_pos_s  = (row_q == RC_LAST) && (col_q == RC_LAST);
    final_pop_s = pop_s && (fifo_count_s == 2'd1) && !inflight_q;
`ifdef FEATUREMAP_STREAM_SRC_ZERO_PAD_EN
    pad_pos_s   = (row_q == {RC_W{1'b0}}) || (row_q == RC_LAST) ||
                  (col_q == {RC_W{1'b0}}) || (col_q == RC_LAST);
    rd_issue_s  = issue_s && !pad_pos_s;
`else
    rd_issue_s  = issue_s;
`endif
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (issue_s && last_pos_s) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (final_pop_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy      = (state_q != ST_IDLE);
    mem_rd_en = rd_issue_s;
  end

  // Raster counters, read address and in-flight tracking.
  always_comb begin
    row_d      = row_q;
    col_d      = col_q;
    addr_d     = addr_q;
    inflight_d = issue_s;
    done_d     = (state_q == ST_DRAIN) && final_pop_s;
    if ((state_q == ST_IDLE) && start) begin
      row_d  = {RC_W{1'b0}};
      col_d  = {RC_W{1'b0}};
      addr_d = {ADDR_WIDTH{1'b0}};
    end else if (issue_s) begin
      if (col_q == RC_LAST) begin
        col_d = {RC_W{1'b0}};
        if (row_q == RC_LAST) begin
          row_d = {RC_W{1'b0}};
        end else begin
          row_d = row_q + RC_ONE;
        end
      end else begin
        col_d = col_q + RC_ONE;
      end
      // Address advances only on real reads; it wraps back to 0 after the
      // last one so a following frame starts clean.
      if (rd_issue_s) begin
        if (addr_q == ADDR_LAST) begin
          addr_d = {ADDR_WIDTH{1'b0}};
        end else begin
          addr_d = addr_q + ADDR_ONE;
        end
      end else begin
        addr_d = addr_q;
      end
    end else begin
      row_d  = row_q;
      col_d  = col_q;
      addr_d = addr_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q      <= {RC_W{1'b0}};
      col_q      <= {RC_W{1'b0}};
      addr_q     <= {ADDR_WIDTH{1'b0}};
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      row_q      <= row_d;
      col_q      <= col_d;
      addr_q     <= addr_d;
      inflight_q <= inflight_d;
      done_q     <= done_d;
    end
  end

`ifdef FEATUREMAP_STREAM_SRC_ZERO_PAD_EN
  // Pad tag travels with the in-flight slot so border beats keep read latency.
  always_comb begin
    inflight_pad_d = issue_s && pad_pos_s;
    if (inflight_pad_q) begin
      push_data_s = {PIX_W{1'b0}};
    end else begin
      push_data_s = mem_rd_data;
    end
  end

  // Pad tag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_pad_q <= 1'b0;
    end else begin
      inflight_pad_q <= inflight_pad_d;
    end
  end
`else
  assign push_data_s = mem_rd_data;
`endif

  assign mem_addr = addr_q;
  assign done     = done_q;

  // Read data is captured exactly one cycle after its strobe.
  stream_skid_fifo #(.W(PIX_W)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_q),
    .push_data (push_data_s),
    .pop       (pop_s),
    .count     (fifo_count_s),
    .data_out  (strm.data_out),
    .valid_out (strm.valid_out)
  );

endmodule

// File: tb/tb_featuremap_stream_source.sv
// ---------------------------------------------------------------------------
// tb_featuremap_stream_source
// Scoreboard bench: expected pixels of a frame are queued when start is
// driven and popped on every stream handshake.
// ---------------------------------------------------------------------------
module tb_featuremap_stream_source;
  import featuremap_stream_pkg::*;

  localparam int IMG  = 4;
  localparam int DW   = 32;
  localparam int NCH  = 2;
  localparam int PW   = DW * NCH;
  localparam int AW   = 4;
`ifdef FEATUREMAP_STREAM_SRC_ZERO_PAD_EN
  localparam int SIDE = IMG + 2;
`else
  localparam int SIDE = IMG;
`endif
  localparam int NBEAT   = SIDE * SIDE;
  localparam int TIMEOUT = 2000;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          busy;
  logic          done;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [PW-1:0] mem_rd_data;

  featuremap_stream_source_if #(.PIX_W(PW)) strm_if ();

  featuremap_stream_source #(
    .DATA_WIDTH (DW),
    .NUM_CH     (NCH),
    .IMG_SIZE   (IMG),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .strm        (strm_if)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int t0 = 0;
  int beats = 0;
  int reads = 0;
  int first_cyc = -1;
  int last_cyc = -1;
  int exp_addr = 0;
  int rdy_mode = 0;
  logic prev_stall = 1'b0;
  logic [PW-1:0] prev_data = '0;
  logic [PW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] req);
    n_chk++;
    if (obs !== req) begin
      n_fail++;
      $display("FAIL %s: observed %0h required %0h", tag, obs, req);
    end
  endtask

  // Buffer word i: channel k holds (k << 16) | i.
  function automatic logic [PW-1:0] mem_word(input int i);
    logic [PW-1:0] w;
    for (int k = 0; k < NCH; k++) w[k*DW +: DW] = DW'((k << 16) | i);
    return w;
  endfunction

  function automatic logic [PW-1:0] exp_pix(input int r, input int c);
`ifdef FEATUREMAP_STREAM_SRC_ZERO_PAD_EN
    if (r == 0 || c == 0 || r == SIDE - 1 || c == SIDE - 1) return '0;
    return mem_word((r - 1) * IMG + (c - 1));
`else
    return mem_word(r * IMG + c);
`endif
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Buffer model: 1-cycle read latency, poison when no read was issued.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem_word(int'(mem_addr));
    else           mem_rd_data <= {NCH{32'hDEAD_BEEF}};
  end

  // Sink ready pattern.
  initial begin
    strm_if.ready_in = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       strm_if.ready_in = 1'b1;
        1:       strm_if.ready_in = ~strm_if.ready_in;
        default: strm_if.ready_in = ($urandom_range(0, 1) != 0);
      endcase
    end
  end

  // Monitor: read order, scoreboard, stall stability, read-ahead bound.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_addr   = 0;
      reads      = 0;
      beats      = 0;
      prev_stall = 1'b0;
    end else begin
      if (start && !busy) begin
        t0        = cyc;
        beats     = 0;
        reads     = 0;
        first_cyc = -1;
        last_cyc  = -1;
        exp_addr  = 0;
      end
      if (prev_stall) begin
        check("stall_valid", strm_if.valid_out, 1);
        check("stall_hold", strm_if.data_out, prev_data);
      end
      if (mem_rd_en) begin
        check("rd_addr", mem_addr, exp_addr);
        exp_addr = (exp_addr + 1) % (IMG * IMG);
        reads++;
      end
      if (strm_if.valid_out && strm_if.ready_in) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", strm_if.data_out, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          check("beat_data", strm_if.data_out, exp_q.pop_front());
        end
        if (first_cyc < 0) first_cyc = cyc - t0;
        last_cyc = cyc - t0;
        beats++;
      end
      if (busy) check("rd_ahead", ((reads - beats) <= 2), 1);
      prev_stall = strm_if.valid_out && !strm_if.ready_in;
      prev_data  = strm_if.data_out;
    end
  end

  task automatic push_frame();
    for (int r = 0; r < SIDE; r++)
      for (int c = 0; c < SIDE; c++)
        exp_q.push_back(exp_pix(r, c));
  endtask

  // Drives a one-cycle start; returns #1 into cycle 1 of the frame.
  task automatic start_frame();
    @(posedge clk);
    #1;
    push_frame();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Returns #1 into the done cycle, with its index relative to start.
  task automatic wait_done(output int dcyc);
    dcyc = -1;
    for (int i = 0; i < TIMEOUT; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        dcyc = cyc - t0;
        break;
      end
    end
    if (dcyc < 0) check("done_timeout", 0, 1);
  endtask

  task automatic check_cycle1();
    @(negedge clk);
    #1;
    check("c1_busy", busy, 1);
    check("c1_rd_en", mem_rd_en, 1);
    check("c1_addr", mem_addr, 0);
  endtask

  initial begin
    int dc;
    int guard;
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_en", mem_rd_en, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_valid", strm_if.valid_out, 0);
    check("rst_data", strm_if.data_out, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Full-rate frame with exact timing.
    rdy_mode = 0;
    start_frame();
    check_cycle1();
    wait_done(dc);
    check("done_cycle", dc, NBEAT + 3);
    check("busy_at_done", busy, 0);
    check("first_lat", first_cyc, 3);
    check("last_beat", last_cyc, NBEAT + 2);
    check("beat_count", beats, NBEAT);
    check("read_count", reads, IMG * IMG);
    check("sb_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
    check("done_pulse", done, 0);

    // Alternating and random backpressure.
    for (int m = 1; m <= 2; m++) begin
      rdy_mode = m;
      start_frame();
      wait_done(dc);
      check("bp_beats", beats, NBEAT);
      check("bp_reads", reads, IMG * IMG);
      check("bp_done_after_last", dc, last_cyc + 1);
      check("bp_sb_empty", exp_q.size(), 0);
    end

    // Starts during a frame are ignored; start in the done cycle is taken.
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    start_frame();
    for (int k = 0; k < 2; k++) begin
      guard = 0;
      while ((cyc - t0) != (k == 0 ? 5 : 10) && guard < 50) begin
        @(posedge clk);
        #1;
        guard++;
      end
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    wait_done(dc);
    check("ign_beats", beats, NBEAT);
    check("ign_sb_empty", exp_q.size(), 0);
    push_frame();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check_cycle1();
    wait_done(dc);
    check("b2b_first_lat", first_cyc, 3);
    check("b2b_beats", beats, NBEAT);
    check("b2b_sb_empty", exp_q.size(), 0);

    // Reset while beat 7 is on the bus.
    start_frame();
    guard = 0;
    do begin
      @(negedge clk);
      #2;
      guard++;
    end while (beats != 8 && guard < TIMEOUT);
    check("beat7_reached", beats, 8);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", strm_if.valid_out, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_rd_en", mem_rd_en, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("post_rst_addr", mem_addr, 0);
    check("post_rst_data", strm_if.data_out, 0);
    start_frame();
    check_cycle1();
    wait_done(dc);
    check("rst_first_lat", first_cyc, 3);
    check("rst_beats", beats, NBEAT);
    check("rst_sb_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
